bsg_fpu_classify_arbiter: RTL and testbench

- Shares one combinational FP operand preprocess/decode datapath among els_p requesters.
- Round-robin arbitration selects one requester per cycle.
- The selected operand is decoded into a one-hot 10-bit class vector (RISC-V fclass encoding) and registered in a single output stage with valid/yumi handshake.
- Keeps a sticky per-requester invalid flag, set whenever a signaling NaN is classified. Sits between issue/decode and the FP result writeback mux.

---
 rtl/bsg_fpu_classify_arbiter.sv | 153 +++++++++++++++
 tb/tb_bsg_fpu_classify_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fpu_classify_arbiter.sv
// bsg_fpu_classify_arbiter
// Round-robin shares one floating-point classify datapath among several requesters.
// The winning operand is decoded into a one-hot RISC-V fclass vector and held in a
// single output register with a valid/yumi handshake. A sticky per-requester flag
// records every signaling NaN that was classified.
module bsg_fpu_classify_arbiter #(
    parameter int els_p = 2,
    parameter int e_p   = 8,
    parameter int m_p   = 23
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic [els_p-1:0]                 v_i,
    input  logic [els_p*(1+e_p+m_p)-1:0]     a_i,
    output logic [els_p-1:0]                 ready_o,
    output logic                             v_o,
    output logic [9:0]                       class_o,
    output logic [$clog2(els_p)-1:0]         id_o,
    input  logic                             yumi_i,
    input  logic [els_p-1:0]                 clear_i,
    output logic [els_p-1:0]                 invalid_o
);

    localparam int opW = 1 + e_p + m_p;
    localparam int idW = $clog2(els_p);

    // Bit 8 of the class vector marks a signaling NaN
    localparam int snanBit = 8;

    logic [idW-1:0]   lastGrant_q, lastGrant_d;
    logic             vOut_q, vOut_d;
    logic [9:0]       class_q, class_d;
    logic [idW-1:0]   id_q, id_d;
    logic [els_p-1:0] invalid_q, invalid_d;

    logic             canAccept;
    logic             grantFound;
    logic [idW-1:0]   grantIdx;
    logic [els_p-1:0] grantOneHot;
    logic [opW-1:0]   selOp;
    logic [9:0]       selClass;
    logic             transfer;

    // Map one operand onto the ten mutually exclusive fclass categories
    function automatic logic [9:0] classify(input logic [opW-1:0] op);
        logic           sign;
        logic [e_p-1:0] expF;
        logic [m_p-1:0] mant;
        logic           expZero, expOnes, mantZero;
        logic [9:0]     cls;
        sign     = op[opW-1];
        expF     = op[opW-2 -: e_p];
        mant     = op[m_p-1:0];
        expZero  = (expF == '0);
        expOnes  = (expF == '1);
        mantZero = (mant == '0);
        cls      = '0;
        cls[0]   =  sign & expOnes & mantZero;
        cls[1]   =  sign & ~expZero & ~expOnes;
        cls[2]   =  sign & expZero & ~mantZero;
        cls[3]   =  sign & expZero & mantZero;
        cls[4]   = ~sign & expZero & mantZero;
        cls[5]   = ~sign & expZero & ~mantZero;
        cls[6]   = ~sign & ~expZero & ~expOnes;
        cls[7]   = ~sign & expOnes & mantZero;
        cls[8]   =  expOnes & ~mantZero & ~mant[m_p-1];
        cls[9]   =  expOnes & mant[m_p-1];
        return cls;
    endfunction

    // Pick the first valid requester after the last winner and route its operand
    always_comb begin
        int idx;
        grantFound  = 1'b0;
        grantIdx    = '0;
        grantOneHot = '0;
        selOp       = '0;
        idx         = 0;
        for (int off = 1; off <= els_p; off++) begin
            idx = (int'(lastGrant_q) + off) % els_p;
            if (!grantFound && v_i[idx]) begin
                grantFound = 1'b1;
                grantIdx   = idW'(idx);
            end
        end
        for (int i = 0; i < els_p; i++) begin
            if (grantIdx == idW'(i)) begin
                grantOneHot[i] = 1'b1;
                selOp          = a_i[i*opW +: opW];
            end
        end
    end

    assign canAccept = reset_n_i & (~vOut_q | yumi_i);
    assign transfer  = canAccept & grantFound;
    assign ready_o   = transfer ? grantOneHot : '0;
    assign selClass  = classify(selOp);

    // Next-state for the output register, round-robin pointer and sticky flags
    always_comb begin
        lastGrant_d = lastGrant_q;
        vOut_d      = vOut_q;
        class_d     = class_q;
        id_d        = id_q;
        invalid_d   = invalid_q & ~clear_i;
        if (transfer) begin
            lastGrant_d = grantIdx;
            vOut_d      = 1'b1;
            class_d     = selClass;
            id_d        = grantIdx;
            if (selClass[snanBit]) begin
                invalid_d = invalid_d | grantOneHot;
            end
        end else if (yumi_i) begin
            vOut_d = 1'b0;
        end
    end

    // All state updates on the rising edge; reset drops any held result
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            lastGrant_q <= idW'(els_p - 1);
            vOut_q      <= 1'b0;
            class_q     <= '0;
            id_q        <= '0;
            invalid_q   <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            vOut_q      <= vOut_d;
            class_q     <= class_d;
            id_q        <= id_d;
            invalid_q   <= invalid_d;
        end
    end

    assign v_o       = vOut_q;
    assign class_o   = class_q;
    assign id_o      = id_q;
    assign invalid_o = invalid_q;

`ifndef SYNTHESIS
    // Catch consumers taking an empty register and any double grant
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(yumi_i && !vOut_q))
                else $error("yumi_i asserted while v_o is low");
            assert ($onehot0(ready_o))
                else $error("ready_o is not one-hot-or-zero");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_fpu_classify_arbiter.sv
// Directed testbench for bsg_fpu_classify_arbiter with two requesters.
// A table of operands with hand-computed fclass vectors is streamed through
// requester 0, and hand-written sequences cover arbitration, back-pressure,
// sticky-flag priority and reset in the middle of traffic.
module tb_bsg_fpu_classify_arbiter;

   logic        clk_i;
   logic        reset_n_i;
   logic [1:0]  v_i;
   logic [63:0] a_i;
   logic [1:0]  ready_o;
   logic        v_o;
   logic [9:0]  class_o;
   logic        id_o;
   logic        yumi_i;
   logic [1:0]  clear_i;
   logic [1:0]  invalid_o;
   logic        yumiReq;

   int total;
   int bad;

   typedef struct {
      logic [31:0] operand;
      logic [9:0]  expClass;
   } vecT;

   vecT vecs[14];

   bsg_fpu_classify_arbiter #(.els_p(2), .e_p(8), .m_p(23)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (v_i),
      .a_i       (a_i),
      .ready_o   (ready_o),
      .v_o       (v_o),
      .class_o   (class_o),
      .id_o      (id_o),
      .yumi_i    (yumi_i),
      .clear_i   (clear_i),
      .invalid_o (invalid_o)
   );

   // The consumer only takes a result that is actually there
   assign yumi_i = yumiReq & v_o;

   // Free-running clock
   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Drive all inputs together and let combinational outputs settle
   task automatic applyStimulus(input logic [1:0] v, input logic [31:0] a0,
                                input logic [31:0] a1, input logic yReq,
                                input logic [1:0] clr);
      v_i     = v;
      a_i     = {a1, a0};
      yumiReq = yReq;
      clear_i = clr;
      #1;
   endtask

   // Advance one rising edge and step just past it
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Compare one value and report any difference
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Main directed sequence
   initial begin
      total = 0;
      bad   = 0;
      vecs[0]  = '{32'h0000_0000, 10'h010};
      vecs[1]  = '{32'h8000_0000, 10'h008};
      vecs[2]  = '{32'h3F80_0000, 10'h040};
      vecs[3]  = '{32'hBF80_0000, 10'h002};
      vecs[4]  = '{32'h0000_0001, 10'h020};
      vecs[5]  = '{32'hFF80_0000, 10'h001};
      vecs[6]  = '{32'hFFC0_0001, 10'h200};
      vecs[7]  = '{32'h7F80_0000, 10'h080};
      vecs[8]  = '{32'h807F_FFFF, 10'h004};
      vecs[9]  = '{32'h7F7F_FFFF, 10'h040};
      vecs[10] = '{32'h0040_0000, 10'h020};
      vecs[11] = '{32'hFFFF_FFFF, 10'h200};
      vecs[12] = '{32'h7FC0_0000, 10'h200};
      vecs[13] = '{32'hFFA0_0000, 10'h100};

      // Reset with requests pending
      reset_n_i = 1'b0;
      applyStimulus(2'b11, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 2'b00);
      checkOutput("reset_ready", {30'd0, ready_o}, 32'd0);
      tick();
      tick();
      checkOutput("reset_v", {31'd0, v_o}, 32'd0);
      checkOutput("reset_class", {22'd0, class_o}, 32'd0);
      checkOutput("reset_id", {31'd0, id_o}, 32'd0);
      checkOutput("reset_invalid", {30'd0, invalid_o}, 32'd0);
      reset_n_i = 1'b1;

      // Single +inf from requester 0
      applyStimulus(2'b01, 32'h7F80_0000, 32'h0, 1'b1, 2'b00);
      checkOutput("t1_ready", {30'd0, ready_o}, 32'h1);
      tick();
      checkOutput("t1_v", {31'd0, v_o}, 32'h1);
      checkOutput("t1_class", {22'd0, class_o}, 32'h080);
      checkOutput("t1_id", {31'd0, id_o}, 32'h0);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
      tick();
      checkOutput("t1_drain_v", {31'd0, v_o}, 32'h0);

      // sNaN from requester 1 sets its sticky flag; set beats clear
      applyStimulus(2'b10, 32'h0, 32'h7FA0_0000, 1'b1, 2'b00);
      checkOutput("t2_ready", {30'd0, ready_o}, 32'h2);
      tick();
      checkOutput("t2_class", {22'd0, class_o}, 32'h100);
      checkOutput("t2_id", {31'd0, id_o}, 32'h1);
      checkOutput("t2_invalid", {30'd0, invalid_o}, 32'h2);
      applyStimulus(2'b10, 32'h0, 32'h7FA0_0000, 1'b1, 2'b10);
      tick();
      checkOutput("t2_setwins", {30'd0, invalid_o}, 32'h2);
      checkOutput("t2_v2", {31'd0, v_o}, 32'h1);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 2'b10);
      tick();
      checkOutput("t2_cleared", {30'd0, invalid_o}, 32'h0);
      checkOutput("t2_drain_v", {31'd0, v_o}, 32'h0);

      // Both requesters streaming at full throughput alternate
      applyStimulus(2'b11, 32'h7FC0_0000, 32'h8000_0001, 1'b1, 2'b00);
      for (int k = 0; k < 6; k++) begin
         tick();
         checkOutput($sformatf("t3_v%0d", k), {31'd0, v_o}, 32'h1);
         checkOutput($sformatf("t3_id%0d", k), {31'd0, id_o}, (k % 2 == 0) ? 32'h0 : 32'h1);
         checkOutput($sformatf("t3_class%0d", k), {22'd0, class_o},
                     (k % 2 == 0) ? 32'h200 : 32'h004);
      end
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
      tick();
      checkOutput("t3_drain_v", {31'd0, v_o}, 32'h0);

      // Back-pressure: result held, then no-bubble handoff to requester 1
      applyStimulus(2'b11, 32'h7FC0_0000, 32'h8000_0001, 1'b0, 2'b00);
      checkOutput("t4_ready0", {30'd0, ready_o}, 32'h1);
      tick();
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("t4_stall_ready%0d", k), {30'd0, ready_o}, 32'h0);
         checkOutput($sformatf("t4_hold_v%0d", k), {31'd0, v_o}, 32'h1);
         checkOutput($sformatf("t4_hold_id%0d", k), {31'd0, id_o}, 32'h0);
         checkOutput($sformatf("t4_hold_class%0d", k), {22'd0, class_o}, 32'h200);
         tick();
      end
      applyStimulus(2'b11, 32'h7FC0_0000, 32'h8000_0001, 1'b1, 2'b00);
      checkOutput("t4_ready1", {30'd0, ready_o}, 32'h2);
      tick();
      checkOutput("t4_next_v", {31'd0, v_o}, 32'h1);
      checkOutput("t4_next_id", {31'd0, id_o}, 32'h1);
      checkOutput("t4_next_class", {22'd0, class_o}, 32'h004);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
      tick();
      checkOutput("t4_drain_v", {31'd0, v_o}, 32'h0);

      // Classification sweep through requester 0
      for (int k = 0; k < 14; k++) begin
         applyStimulus(2'b01, vecs[k].operand, 32'h0, 1'b1, 2'b00);
         tick();
         checkOutput($sformatf("sweep%0d_v", k), {31'd0, v_o}, 32'h1);
         checkOutput($sformatf("sweep%0d_class", k), {22'd0, class_o}, {22'd0, vecs[k].expClass});
         checkOutput($sformatf("sweep%0d_id", k), {31'd0, id_o}, 32'h0);
      end
      checkOutput("sweep_invalid", {30'd0, invalid_o}, 32'h1);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
      tick();
      checkOutput("sweep_drain_v", {31'd0, v_o}, 32'h0);

      // Reset while a result is held and requests are active
      applyStimulus(2'b11, 32'h3F80_0000, 32'hBF80_0000, 1'b0, 2'b00);
      tick();
      checkOutput("t6_pre_v", {31'd0, v_o}, 32'h1);
      checkOutput("t6_pre_id", {31'd0, id_o}, 32'h1);
      reset_n_i = 1'b0;
      #1;
      checkOutput("t6_reset_ready", {30'd0, ready_o}, 32'h0);
      tick();
      checkOutput("t6_reset_v", {31'd0, v_o}, 32'h0);
      checkOutput("t6_reset_invalid", {30'd0, invalid_o}, 32'h0);
      reset_n_i = 1'b1;
      #1;
      checkOutput("t6_post_ready", {30'd0, ready_o}, 32'h1);
      tick();
      checkOutput("t6_post_v", {31'd0, v_o}, 32'h1);
      checkOutput("t6_post_id", {31'd0, id_o}, 32'h0);
      checkOutput("t6_post_class", {22'd0, class_o}, 32'h040);
      applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 2'b00);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
